// File: rtl/uart_tx_arbiter_if.sv
// Bundles the byte-source handshake and UART transmitter pins of uart_tx_arbiter.
// master = arbiter side, slave = sources/transmitter side.
interface uart_tx_arbiter_if #(
  parameter int unsigned NREQ = 4,
  parameter int unsigned IDW  = 2
);
  logic [NREQ-1:0]   req_valid;
  logic [8*NREQ-1:0] req_data;
  logic [NREQ-1:0]   req_ready;
  logic              tx_start;
  logic [7:0]        tx_data;
  logic              tx_ready;
  logic              busy;
  logic [IDW-1:0]    grant_id;
  logic              frame_done;

  modport master (
    input  req_valid, req_data, tx_ready,
    output req_ready, tx_start, tx_data, busy, grant_id, frame_done
  );

  modport slave (
    output req_valid, req_data, tx_ready,
    input  req_ready, tx_start, tx_data, busy, grant_id, frame_done
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter among NREQ byte sources.
// Optional UART_ARB_TAG_EN: prefix a tag byte (TAG_BASE|id) whenever the source changes.
module uart_tx_arbiter #(
  parameter int unsigned NREQ     = 4,
  parameter int unsigned IDW      = 2,
  parameter logic [7:0]  TAG_BASE = 8'hF0
) (
  input logic               clk,
  input logic               rst,
  uart_tx_arbiter_if.master bus
);
  localparam logic [1:0] StIdle     = 2'd0;
  localparam logic [1:0] StIssue    = 2'd1;
  localparam logic [1:0] StWaitBusy = 2'd2;
  localparam logic [1:0] StWaitDone = 2'd3;

  logic [1:0]     state_q, state_d;
  logic [IDW-1:0] ptr_q, gid_q, sel_id, ptr_nxt, cand;
  logic [7:0]     buf_q, sel_data;
  logic           found, grant, pend;
  int unsigned    slot;

  // First valid source at or after ptr, wrapping modulo NREQ.
  always_comb begin
    found    = 1'b0;
    sel_id   = '0;
    sel_data = '0;
    slot     = 0;
    cand     = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      slot = 32'(ptr_q) + k;
      if (slot >= NREQ) slot = slot - NREQ;
      cand = slot[IDW-1:0];
      if (!found && bus.req_valid[cand]) begin
        found    = 1'b1;
        sel_id   = cand;
        sel_data = bus.req_data[{cand, 3'b000} +: 8];
      end
    end
  end

  assign ptr_nxt = (32'(sel_id) == NREQ - 1) ? '0 : sel_id + IDW'(1);
  assign grant   = !rst && (state_q == StIdle) && bus.tx_ready && found;

`ifdef UART_ARB_TAG_EN
  logic [IDW-1:0] last_id_q;
  logic           last_valid_q, pend_q, need_tag;
  logic [7:0]     data_q;

  assign need_tag = !last_valid_q || (last_id_q != sel_id);
  assign pend     = pend_q;
`else
  assign pend = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:     if (grant) state_d = StIssue;
      StIssue:    state_d = StWaitBusy;
      StWaitBusy: if (!bus.tx_ready) state_d = StWaitDone;
      StWaitDone: if (bus.tx_ready) state_d = pend ? StIssue : StIdle;
      default:    state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      ptr_q   <= '0;
      gid_q   <= '0;
      buf_q   <= '0;
`ifdef UART_ARB_TAG_EN
      last_id_q    <= '0;
      last_valid_q <= 1'b0;
      pend_q       <= 1'b0;
      data_q       <= '0;
`endif
    end else begin
      state_q <= state_d;
      if (grant) begin
        gid_q <= sel_id;
        ptr_q <= ptr_nxt;
`ifdef UART_ARB_TAG_EN
        last_id_q    <= sel_id;
        last_valid_q <= 1'b1;
        if (need_tag) begin
          buf_q  <= TAG_BASE | 8'(sel_id);
          data_q <= sel_data;
          pend_q <= 1'b1;
        end else begin
          buf_q <= sel_data;
        end
`else
        buf_q <= sel_data;
`endif
      end
`ifdef UART_ARB_TAG_EN
      // Tag frame finished: the held data byte goes out without revisiting IDLE.
      if ((state_q == StWaitDone) && bus.tx_ready && pend_q) begin
        buf_q  <= data_q;
        pend_q <= 1'b0;
      end
`endif
    end
  end

  always_comb begin
    bus.req_ready  = grant ? (NREQ'(1) << sel_id) : '0;
    bus.tx_start   = (state_q == StIssue);
    bus.tx_data    = (state_q == StIssue) ? buf_q : 8'h00;
    bus.busy       = (state_q != StIdle);
    bus.grant_id   = gid_q;
    bus.frame_done = (state_q == StWaitDone) && bus.tx_ready && !pend;
  end
endmodule
